// File: rtl/aidan_mcnay_prime_ctrl_if.sv
// aidan_mcnay_prime_ctrl_if: candidate, result and remainder-unit streams of the prime sequencer
interface aidan_mcnay_prime_ctrl_if #(parameter int NBITS = 16);
  logic [NBITS-1:0] in_num;
  logic             istream_val;
  logic             istream_rdy;
  logic             is_prime;
  logic [NBITS-1:0] factor;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [NBITS-1:0] div_opa;
  logic [NBITS-1:0] div_opb;
  logic             div_istream_val;
  logic             div_istream_rdy;
  logic [NBITS-1:0] div_result;
  logic             div_ostream_val;
  logic             div_ostream_rdy;
  modport master (
    input  in_num, istream_val, ostream_rdy, div_istream_rdy, div_result, div_ostream_val,
    output istream_rdy, is_prime, factor, ostream_val, div_opa, div_opb, div_istream_val, div_ostream_rdy
  );
  modport slave (
    output in_num, istream_val, ostream_rdy, div_istream_rdy, div_result, div_ostream_val,
    input  istream_rdy, is_prime, factor, ostream_val, div_opa, div_opb, div_istream_val, div_ostream_rdy
  );
endinterface

// File: rtl/aidan_mcnay_prime_ctrl.sv
// aidan_mcnay_prime_ctrl: trial-division sequencer driving an external remainder unit
module aidan_mcnay_prime_ctrl #(parameter int NBITS = 16) (
  input logic                    clk,
  input logic                    reset,
  aidan_mcnay_prime_ctrl_if.master bus_io
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]         state_q, state_d;
  logic [NBITS-1:0]   n_q, n_d, dv_q, dv_d, factor_q, factor_d;
  logic               prime_q, prime_d;
  logic [2*NBITS-1:0] sq;
  // full-width square so the d*d > n test can never overflow
  assign sq = {{NBITS{1'b0}}, dv_q} * {{NBITS{1'b0}}, dv_q};
  assign bus_io.istream_rdy     = state_q == IDLE && !reset;
  assign bus_io.ostream_val     = state_q == DONE;
  assign bus_io.div_istream_val = state_q == REQ;
  assign bus_io.div_ostream_rdy = state_q == WAIT;
  assign bus_io.div_opa         = n_q;
  assign bus_io.div_opb         = dv_q;
  assign bus_io.is_prime        = prime_q;
  assign bus_io.factor          = factor_q;
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    dv_d     = dv_q;
    prime_d  = prime_q;
    factor_d = factor_q;
    case (state_q)
      IDLE: if (bus_io.istream_val) begin
        n_d     = bus_io.in_num;
        dv_d    = NBITS'(2);
        state_d = CHECK;
      end
      CHECK: begin
        if (n_q < NBITS'(2) || sq > {{NBITS{1'b0}}, n_q}) begin
          prime_d  = n_q >= NBITS'(2);
          factor_d = '0;
          state_d  = DONE;
        end else state_d = REQ;
      end
      REQ: state_d = bus_io.div_istream_rdy ? WAIT : REQ;
      WAIT: if (bus_io.div_ostream_val) begin
        if (bus_io.div_result == '0) begin
          prime_d  = 1'b0;
          factor_d = dv_q;
          state_d  = DONE;
        end else begin
          dv_d    = dv_q == NBITS'(2) ? NBITS'(3) : dv_q + NBITS'(2);
          state_d = CHECK;
        end
      end
      DONE: state_d = bus_io.ostream_rdy ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      dv_q     <= '0;
      prime_q  <= 1'b0;
      factor_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      dv_q     <= dv_d;
      prime_q  <= prime_d;
      factor_q <= factor_d;
    end
  end
endmodule

// File: tb/tb_aidan_mcnay_prime_ctrl.sv
// tb_aidan_mcnay_prime_ctrl: directed vectors plus handshake/reset corner sequences
module tb_aidan_mcnay_prime_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  aidan_mcnay_prime_ctrl_if #(.NBITS(16)) bus();
  aidan_mcnay_prime_ctrl #(.NBITS(16)) dut (.clk(clk), .reset(reset), .bus_io(bus));
  typedef struct {
    logic [15:0] n;
    logic        p;
    logic [15:0] f;
    int          reqs;
    logic [15:0] last;
  } vec_t;
  int passed = 0;
  int total = 0;
  int lat = 0;
  bit rdy_en = 1'b1;
  bit spur = 1'b0;
  bit busy = 1'b0, oval = 1'b0, req_f = 1'b0, rsp_f = 1'b0;
  int cnt = 0;
  logic [15:0] m_a = 16'd0, m_b = 16'd1, cur_n = 16'd0;
  logic [15:0] divs[$];
  bit opa_bad = 1'b0;
  // behavioural remainder unit: one outstanding request, programmable latency
  initial begin
    bus.div_istream_rdy = 1'b0;
    bus.div_ostream_val = 1'b0;
    bus.div_result = 16'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0; oval = 1'b0; req_f = 1'b0; rsp_f = 1'b0;
      end else begin
        if (rsp_f) oval = 1'b0;
        if (req_f) begin busy = 1'b1; cnt = lat; end
        if (busy && cnt == 0) begin busy = 1'b0; oval = 1'b1; end
        else if (busy) cnt--;
      end
      bus.div_istream_rdy = rdy_en && !busy && !oval && !reset;
      bus.div_ostream_val = oval || spur;
      bus.div_result = oval ? m_a % m_b : 16'd0;
      req_f = !reset && bus.div_istream_val && bus.div_istream_rdy;
      rsp_f = !reset && bus.div_ostream_val && bus.div_ostream_rdy;
      if (req_f) begin
        m_a = bus.div_opa;
        m_b = bus.div_opb;
        divs.push_back(m_b);
        if (m_a != cur_n) opa_bad = 1'b1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  task automatic send(input logic [15:0] n);
    int t = 0;
    @(negedge clk);
    while (!bus.istream_rdy && t < 100) begin @(negedge clk); t++; end
    if (!bus.istream_rdy) begin total++; $display("FAIL accept n=%0d: istream_rdy never rose", n); end
    cur_n = n;
    divs.delete();
    opa_bad = 1'b0;
    bus.in_num = n;
    bus.istream_val = 1'b1;
    @(negedge clk);
    bus.istream_val = 1'b0;
  endtask
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!bus.ostream_val && cyc < 3000) begin @(negedge clk); cyc++; end
    if (!bus.ostream_val) begin total++; $display("FAIL result timeout: ostream_val got 0, expected 1"); end
  endtask
  task automatic wait_sig(input string nm, input int which);
    int t = 0;
    while (!(which == 0 ? bus.div_istream_val : bus.div_ostream_rdy) && t < 50) begin @(negedge clk); t++; end
    if (!(which == 0 ? bus.div_istream_val : bus.div_ostream_rdy)) begin
      total++; $display("FAIL %s timeout: got 0, expected 1", nm);
    end
  endtask
  task automatic chk_reset_outs(input string nm);
    chk({nm, " ostream_val"}, bus.ostream_val, 0);
    chk({nm, " div_istream_val"}, bus.div_istream_val, 0);
    chk({nm, " div_ostream_rdy"}, bus.div_ostream_rdy, 0);
    chk({nm, " is_prime"}, bus.is_prime, 0);
    chk({nm, " factor"}, bus.factor, 0);
  endtask
  initial begin
    vec_t v[14];
    logic [15:0] e97[5];
    logic [15:0] a, b;
    int cyc;
    v[0]  = '{16'd0,     1'b0, 16'd0,  0,   16'd0};
    v[1]  = '{16'd1,     1'b0, 16'd0,  0,   16'd0};
    v[2]  = '{16'd2,     1'b1, 16'd0,  0,   16'd0};
    v[3]  = '{16'd3,     1'b1, 16'd0,  0,   16'd0};
    v[4]  = '{16'd4,     1'b0, 16'd2,  1,   16'd2};
    v[5]  = '{16'd5,     1'b1, 16'd0,  1,   16'd2};
    v[6]  = '{16'd9,     1'b0, 16'd3,  2,   16'd3};
    v[7]  = '{16'd25,    1'b0, 16'd5,  3,   16'd5};
    v[8]  = '{16'd49,    1'b0, 16'd7,  4,   16'd7};
    v[9]  = '{16'd91,    1'b0, 16'd7,  4,   16'd7};
    v[10] = '{16'd97,    1'b1, 16'd0,  5,   16'd9};
    v[11] = '{16'd121,   1'b0, 16'd11, 6,   16'd11};
    v[12] = '{16'd65521, 1'b1, 16'd0,  128, 16'd255};
    v[13] = '{16'd65535, 1'b0, 16'd3,  2,   16'd3};
    e97 = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd9};
    bus.in_num = 16'd0;
    bus.istream_val = 1'b0;
    bus.ostream_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    chk("reset istream_rdy", bus.istream_rdy, 0);
    reset = 1'b0;
    #1;
    chk("post-reset istream_rdy", bus.istream_rdy, 1);
    for (int i = 0; i < 14; i++) begin
      send(v[i].n);
      wait_out(cyc);
      chk($sformatf("n=%0d is_prime", v[i].n), bus.is_prime, v[i].p);
      chk($sformatf("n=%0d factor", v[i].n), bus.factor, v[i].f);
      chk($sformatf("n=%0d requests", v[i].n), divs.size(), v[i].reqs);
      chk($sformatf("n=%0d last divisor", v[i].n), divs.size() > 0 ? divs[$] : 16'd0, v[i].last);
      chk($sformatf("n=%0d div_opa", v[i].n), opa_bad, 0);
      chk($sformatf("n=%0d latency", v[i].n), cyc, 3 * v[i].reqs + (v[i].f != 0 ? 1 : 2));
      @(negedge clk);
      chk($sformatf("n=%0d ostream_val drop", v[i].n), bus.ostream_val, 0);
      chk($sformatf("n=%0d back to idle", v[i].n), bus.istream_rdy, 1);
    end
    send(16'd97);
    wait_out(cyc);
    chk("97 request count", divs.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("97 divisor %0d", i), i < divs.size() ? divs[i] : 16'hffff, e97[i]);
    @(negedge clk);
    rdy_en = 1'b0;
    send(16'd91);
    wait_sig("req backpressure", 0);
    a = bus.div_opa;
    b = bus.div_opb;
    chk("bp first opb", b, 2);
    chk("bp opa", a, 91);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d div_istream_val", i), bus.div_istream_val, 1);
      chk($sformatf("bp%0d div_opa", i), bus.div_opa, a);
      chk($sformatf("bp%0d div_opb", i), bus.div_opb, b);
    end
    rdy_en = 1'b1;
    wait_out(cyc);
    chk("bp 91 factor", bus.factor, 7);
    @(negedge clk);
    bus.ostream_rdy = 1'b0;
    send(16'd25);
    wait_out(cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("obp%0d ostream_val", i), bus.ostream_val, 1);
      chk($sformatf("obp%0d is_prime", i), bus.is_prime, 0);
      chk($sformatf("obp%0d factor", i), bus.factor, 5);
      chk($sformatf("obp%0d istream_rdy", i), bus.istream_rdy, 0);
    end
    bus.ostream_rdy = 1'b1;
    @(negedge clk);
    chk("obp release ostream_val", bus.ostream_val, 0);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("spurious istream_rdy", bus.istream_rdy, 1);
    chk("spurious ostream_val", bus.ostream_val, 0);
    chk("spurious div_istream_val", bus.div_istream_val, 0);
    lat = 6;
    send(16'd97);
    wait_sig("wait state", 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid reset");
    chk("mid reset istream_rdy", bus.istream_rdy, 0);
    reset = 1'b0;
    #1;
    chk("after mid reset istream_rdy", bus.istream_rdy, 1);
    lat = 0;
    send(16'd25);
    wait_out(cyc);
    chk("post reset 25 is_prime", bus.is_prime, 0);
    chk("post reset 25 factor", bus.factor, 5);
    chk("post reset 25 requests", divs.size(), 3);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
